// File: rtl/battleship_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : battleship_pkg
//  Description : Shared PS/2 set-2 scan codes, key classes and entry phases
//                for the Battleship shot-entry path.
//  Revision    : 1.0  initial release
// ============================================================================
package battleship_pkg;

   typedef logic [3:0] board_idx_t;

   typedef enum logic [2:0] {
      KC_LETTER = 3'd0,
      KC_DIGIT  = 3'd1,
      KC_ENTER  = 3'd2,
      KC_BKSP   = 3'd3,
      KC_OTHER  = 3'd4
   } key_class_t;

   typedef enum logic [1:0] {
      PH_LETTER = 2'd0,
      PH_NUMBER = 2'd1,
      PH_ENTER  = 2'd2,
      PH_HOLD   = 2'd3
   } phase_t;

   // Row letters A..J
   localparam logic [7:0] c_SC_A = 8'h1C;
   localparam logic [7:0] c_SC_B = 8'h32;
   localparam logic [7:0] c_SC_C = 8'h21;
   localparam logic [7:0] c_SC_D = 8'h23;
   localparam logic [7:0] c_SC_E = 8'h24;
   localparam logic [7:0] c_SC_F = 8'h2B;
   localparam logic [7:0] c_SC_G = 8'h34;
   localparam logic [7:0] c_SC_H = 8'h33;
   localparam logic [7:0] c_SC_I = 8'h43;
   localparam logic [7:0] c_SC_J = 8'h3B;

   // Column digits; key 0 is column ten
   localparam logic [7:0] c_SC_1 = 8'h16;
   localparam logic [7:0] c_SC_2 = 8'h1E;
   localparam logic [7:0] c_SC_3 = 8'h26;
   localparam logic [7:0] c_SC_4 = 8'h25;
   localparam logic [7:0] c_SC_5 = 8'h2E;
   localparam logic [7:0] c_SC_6 = 8'h36;
   localparam logic [7:0] c_SC_7 = 8'h3D;
   localparam logic [7:0] c_SC_8 = 8'h3E;
   localparam logic [7:0] c_SC_9 = 8'h46;
   localparam logic [7:0] c_SC_0 = 8'h45;

   localparam logic [7:0] c_SC_ENTER = 8'h5A;
   localparam logic [7:0] c_SC_BKSP  = 8'h66;
   localparam logic [7:0] c_SC_BREAK = 8'hF0;
   localparam logic [7:0] c_SC_EXT   = 8'hE0;

endpackage
`default_nettype wire

// File: rtl/scan_code_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : scan_code_decoder
//  Description : Combinational make-code lookup: byte -> {key class, index}.
//  Revision    : 1.0  initial release
// ============================================================================
module scan_code_decoder
   import battleship_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [2:0] o_class,
   output logic [3:0] o_index
);

   always_comb begin
      o_class = KC_OTHER;
      o_index = 4'd0;
      case (i_byte)
         c_SC_A:     begin o_class = KC_LETTER; o_index = 4'd0; end
         c_SC_B:     begin o_class = KC_LETTER; o_index = 4'd1; end
         c_SC_C:     begin o_class = KC_LETTER; o_index = 4'd2; end
         c_SC_D:     begin o_class = KC_LETTER; o_index = 4'd3; end
         c_SC_E:     begin o_class = KC_LETTER; o_index = 4'd4; end
         c_SC_F:     begin o_class = KC_LETTER; o_index = 4'd5; end
         c_SC_G:     begin o_class = KC_LETTER; o_index = 4'd6; end
         c_SC_H:     begin o_class = KC_LETTER; o_index = 4'd7; end
         c_SC_I:     begin o_class = KC_LETTER; o_index = 4'd8; end
         c_SC_J:     begin o_class = KC_LETTER; o_index = 4'd9; end
         c_SC_1:     begin o_class = KC_DIGIT;  o_index = 4'd0; end
         c_SC_2:     begin o_class = KC_DIGIT;  o_index = 4'd1; end
         c_SC_3:     begin o_class = KC_DIGIT;  o_index = 4'd2; end
         c_SC_4:     begin o_class = KC_DIGIT;  o_index = 4'd3; end
         c_SC_5:     begin o_class = KC_DIGIT;  o_index = 4'd4; end
         c_SC_6:     begin o_class = KC_DIGIT;  o_index = 4'd5; end
         c_SC_7:     begin o_class = KC_DIGIT;  o_index = 4'd6; end
         c_SC_8:     begin o_class = KC_DIGIT;  o_index = 4'd7; end
         c_SC_9:     begin o_class = KC_DIGIT;  o_index = 4'd8; end
         c_SC_0:     begin o_class = KC_DIGIT;  o_index = 4'd9; end
         c_SC_ENTER: o_class = KC_ENTER;
         c_SC_BKSP:  o_class = KC_BKSP;
         default:    ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/shot_command_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : shot_command_encoder
//  Description : Turns PS/2 make codes into row/column/Enter shot commands
//                with a valid/ready handshake and a turn toggle.
//  Revision    : 1.0  initial release
// ============================================================================
module shot_command_encoder
   import battleship_pkg::*;
(
   input  logic       clock27,
   input  logic       reset_n,
   input  logic [7:0] key_byte,
   input  logic       key_valid,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [3:0] cmd_row,
   output logic [3:0] cmd_col,
   output logic       cmd_player,
   output logic [1:0] entry_phase,
   output logic       key_error
);

   logic [2:0] w_class_raw;
   board_idx_t w_index;
   key_class_t w_class;

   scan_code_decoder u_decoder (
      .i_byte  (key_byte),
      .o_class (w_class_raw),
      .o_index (w_index)
   );

   assign w_class = key_class_t'(w_class_raw);

   logic       r_break_pend;
   logic       r_ext_pend;
   logic       w_make;
   phase_t     r_phase;
   phase_t     w_phase_next;
   logic       w_handshake;
   logic       w_err;
   logic       w_latch_row;
   logic       w_latch_col;
   board_idx_t r_row;
   board_idx_t r_col;
   logic       r_player;
   logic       r_key_error;

   // A byte is a real make code only if no prefix is pending and it is not a prefix itself.
   assign w_make = key_valid && !r_break_pend && !r_ext_pend &&
                   (key_byte != c_SC_BREAK) && (key_byte != c_SC_EXT);

   assign w_handshake = (r_phase == PH_HOLD) && cmd_ready;

   always_ff @(posedge clock27 or negedge reset_n) begin
      if (!reset_n) begin
         r_break_pend <= 1'b0;
         r_ext_pend   <= 1'b0;
      end else if (key_valid) begin
         if (r_break_pend) begin
            r_break_pend <= 1'b0;
            r_ext_pend   <= 1'b0;
         end else if (key_byte == c_SC_BREAK) begin
            r_break_pend <= 1'b1;
         end else if (r_ext_pend) begin
            r_ext_pend   <= 1'b0;
         end else if (key_byte == c_SC_EXT) begin
            r_ext_pend   <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock27 or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= PH_LETTER;
      end else begin
         r_phase <= w_phase_next;
      end
   end

   always_comb begin
      w_phase_next = r_phase;
      case (r_phase)
         PH_LETTER: begin
            if (w_make && (w_class == KC_LETTER)) w_phase_next = PH_NUMBER;
         end
         PH_NUMBER: begin
            if (w_make && (w_class == KC_DIGIT))  w_phase_next = PH_ENTER;
            if (w_make && (w_class == KC_BKSP))   w_phase_next = PH_LETTER;
         end
         PH_ENTER: begin
            if (w_make && (w_class == KC_ENTER))  w_phase_next = PH_HOLD;
            if (w_make && (w_class == KC_BKSP))   w_phase_next = PH_NUMBER;
         end
         PH_HOLD: begin
            if (w_handshake) w_phase_next = PH_LETTER;
         end
         default: w_phase_next = PH_LETTER;
      endcase
   end

   always_comb begin
      w_err       = 1'b0;
      w_latch_row = 1'b0;
      w_latch_col = 1'b0;
      case (r_phase)
         PH_LETTER: begin
            w_latch_row = w_make && (w_class == KC_LETTER);
            w_err       = w_make && ((w_class == KC_DIGIT) || (w_class == KC_ENTER));
         end
         PH_NUMBER: begin
            w_latch_col = w_make && (w_class == KC_DIGIT);
            w_err       = w_make && ((w_class == KC_LETTER) || (w_class == KC_ENTER));
         end
         PH_ENTER: begin
            w_err       = w_make && ((w_class == KC_LETTER) || (w_class == KC_DIGIT));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock27 or negedge reset_n) begin
      if (!reset_n) begin
         r_row       <= 4'd0;
         r_col       <= 4'd0;
         r_player    <= 1'b0;
         r_key_error <= 1'b0;
      end else begin
         r_key_error <= w_err;
         if (w_latch_row) r_row <= w_index;
         if (w_latch_col) r_col <= w_index;
         if (w_handshake) r_player <= ~r_player;
      end
   end

   // HOLD is exactly the "command pending" state, so valid drops with an async reset.
   assign cmd_valid   = (r_phase == PH_HOLD);
   assign cmd_row     = r_row;
   assign cmd_col     = r_col;
   assign cmd_player  = r_player;
   assign entry_phase = r_phase;
   assign key_error   = r_key_error;

endmodule
`default_nettype wire

// File: tb/tb_shot_command_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shot_command_encoder
//  Description : Self-checking bench: vector table, directed sequences and a
//                random run against a behavioural shot-entry model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shot_command_encoder;

   logic       clock27;
   logic       reset_n;
   logic [7:0] key_byte;
   logic       key_valid;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [3:0] cmd_row;
   logic [3:0] cmd_col;
   logic       cmd_player;
   logic [1:0] entry_phase;
   logic       key_error;

   shot_command_encoder dut (
      .clock27     (clock27),
      .reset_n     (reset_n),
      .key_byte    (key_byte),
      .key_valid   (key_valid),
      .cmd_ready   (cmd_ready),
      .cmd_valid   (cmd_valid),
      .cmd_row     (cmd_row),
      .cmd_col     (cmd_col),
      .cmd_player  (cmd_player),
      .entry_phase (entry_phase),
      .key_error   (key_error)
   );

   initial clock27 = 1'b0;
   always #5 clock27 = ~clock27;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] letter_codes [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
   logic [7:0] digit_codes  [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
   logic [7:0] rand_pool    [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                                     8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
                                     8'h5A, 8'h66, 8'hF0, 8'hE0, 8'h29, 8'h5A};

   // Model: entry advances when the key kind matches the phase number
   // (0 letter, 1 digit, 2 enter), backspace steps back, other entry keys are errors.
   int         m_phase;
   logic [3:0] m_row, m_col;
   logic       m_player, m_err, m_brk, m_ext;

   function automatic void model_reset();
      m_phase = 0; m_row = 4'd0; m_col = 4'd0;
      m_player = 1'b0; m_err = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
   endfunction

   function automatic void lookup(input logic [7:0] b, output int kind, output int idx);
      kind = 4; idx = 0;
      for (int i = 0; i < 10; i++) begin
         if (b == letter_codes[i]) begin kind = 0; idx = i; end
         if (b == digit_codes[i])  begin kind = 1; idx = i; end
      end
      if (b == 8'h5A) kind = 2;
      if (b == 8'h66) kind = 3;
   endfunction

   function automatic void model_step(input logic kv, input logic [7:0] kb, input logic rdy);
      logic is_make;
      int   kind, idx;
      is_make = 1'b0;
      m_err   = 1'b0;
      if (kv) begin
         if (m_brk)            begin m_brk = 1'b0; m_ext = 1'b0; end
         else if (kb == 8'hF0) m_brk = 1'b1;
         else if (m_ext)       m_ext = 1'b0;
         else if (kb == 8'hE0) m_ext = 1'b1;
         else                  is_make = 1'b1;
      end
      if (m_phase == 3) begin
         if (rdy) begin m_phase = 0; m_player = ~m_player; end
      end else if (is_make) begin
         lookup(kb, kind, idx);
         if (kind == m_phase) begin
            if (m_phase == 0) m_row = 4'(idx);
            if (m_phase == 1) m_col = 4'(idx);
            m_phase = m_phase + 1;
         end else if (kind == 3) begin
            if (m_phase > 0) m_phase = m_phase - 1;
         end else if (kind < 3) begin
            m_err = 1'b1;
         end
      end
   endfunction

   function automatic logic [12:0] model_vec();
      return {(m_phase == 3), m_row, m_col, m_player, 2'(m_phase), m_err};
   endfunction

   function automatic logic [12:0] dut_vec();
      return {cmd_valid, cmd_row, cmd_col, cmd_player, entry_phase, key_error};
   endfunction

   task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic kv, input logic [7:0] kb, input logic rdy);
      key_valid = kv; key_byte = kb; cmd_ready = rdy;
      model_step(kv, kb, rdy);
      @(posedge clock27); #1;
      chk("model", dut_vec(), model_vec());
      key_valid = 1'b0;
   endtask

   typedef struct {
      logic       kv;
      logic [7:0] kb;
      logic       rdy;
      logic [12:0] exp;   // {valid,row,col,player,phase,err}
   } vec_t;

   vec_t tbl [16];

   initial begin
      tbl[0]  = '{1'b1, 8'h1C, 1'b1, {1'b0, 4'd0, 4'd0, 1'b0, 2'd1, 1'b0}};
      tbl[1]  = '{1'b1, 8'hF0, 1'b1, {1'b0, 4'd0, 4'd0, 1'b0, 2'd1, 1'b0}};
      tbl[2]  = '{1'b1, 8'h1C, 1'b1, {1'b0, 4'd0, 4'd0, 1'b0, 2'd1, 1'b0}};
      tbl[3]  = '{1'b1, 8'h16, 1'b1, {1'b0, 4'd0, 4'd0, 1'b0, 2'd2, 1'b0}};
      tbl[4]  = '{1'b1, 8'hF0, 1'b1, {1'b0, 4'd0, 4'd0, 1'b0, 2'd2, 1'b0}};
      tbl[5]  = '{1'b1, 8'h16, 1'b1, {1'b0, 4'd0, 4'd0, 1'b0, 2'd2, 1'b0}};
      tbl[6]  = '{1'b1, 8'h5A, 1'b1, {1'b1, 4'd0, 4'd0, 1'b0, 2'd3, 1'b0}};
      tbl[7]  = '{1'b1, 8'hF0, 1'b1, {1'b0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0}};
      tbl[8]  = '{1'b1, 8'h5A, 1'b1, {1'b0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0}};
      tbl[9]  = '{1'b1, 8'h16, 1'b1, {1'b0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b1}};
      tbl[10] = '{1'b0, 8'h00, 1'b1, {1'b0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0}};
      tbl[11] = '{1'b1, 8'h1C, 1'b1, {1'b0, 4'd0, 4'd0, 1'b1, 2'd1, 1'b0}};
      tbl[12] = '{1'b1, 8'h5A, 1'b1, {1'b0, 4'd0, 4'd0, 1'b1, 2'd1, 1'b1}};
      tbl[13] = '{1'b0, 8'h00, 1'b1, {1'b0, 4'd0, 4'd0, 1'b1, 2'd1, 1'b0}};
      tbl[14] = '{1'b1, 8'h66, 1'b1, {1'b0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0}};
      tbl[15] = '{1'b1, 8'h66, 1'b1, {1'b0, 4'd0, 4'd0, 1'b1, 2'd0, 1'b0}};

      reset_n = 1'b0; key_valid = 1'b0; key_byte = 8'h00; cmd_ready = 1'b0;
      model_reset();
      #12;
      chk("reset", dut_vec(), 13'd0);
      #1 reset_n = 1'b1;
      @(posedge clock27); #1;

      // Shot A1 with the decider ready, then error pulses and backspace in LETTER
      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].kv, tbl[i].kb, tbl[i].rdy);
         chk($sformatf("tbl[%0d]", i), dut_vec(), tbl[i].exp);
      end

      // J10 held while the decider stalls; keys during HOLD are ignored
      cycle(1'b1, 8'h3B, 1'b0);
      cycle(1'b1, 8'h45, 1'b0);
      cycle(1'b1, 8'h5A, 1'b0);
      chk("hold_enter", {4'd0, cmd_valid, cmd_row, cmd_col}, {4'd0, 1'b1, 4'd9, 4'd9});
      cycle(1'b1, 8'h1C, 1'b0);
      cycle(1'b1, 8'h16, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
      chk("hold_stable", {2'd0, cmd_valid, cmd_row, cmd_col, entry_phase}, {2'd0, 1'b1, 4'd9, 4'd9, 2'd3});
      cycle(1'b0, 8'h00, 1'b1);
      chk("hs_drop", {11'd0, cmd_valid, cmd_player}, {11'd0, 1'b0, 1'b0});

      // Break of a letter alone changes nothing; I5 with backspaces and keypad Enter
      cycle(1'b1, 8'hF0, 1'b0);
      cycle(1'b1, 8'h1C, 1'b0);
      chk("break_only", {10'd0, entry_phase, key_error}, {10'd0, 2'd0, 1'b0});
      cycle(1'b1, 8'h24, 1'b0);
      cycle(1'b1, 8'h66, 1'b0);
      cycle(1'b1, 8'h43, 1'b0);
      cycle(1'b1, 8'h26, 1'b0);
      cycle(1'b1, 8'h66, 1'b0);
      cycle(1'b1, 8'h2E, 1'b0);
      cycle(1'b1, 8'hE0, 1'b0);
      cycle(1'b1, 8'h5A, 1'b0);
      chk("kp_enter", {10'd0, entry_phase, cmd_valid}, {10'd0, 2'd2, 1'b0});
      cycle(1'b1, 8'h5A, 1'b0);
      chk("i5_cmd", {4'd0, cmd_valid, cmd_row, cmd_col}, {4'd0, 1'b1, 4'd8, 4'd4});
      cycle(1'b0, 8'h00, 1'b1);
      chk("i5_player", {12'd0, cmd_player}, {12'd0, 1'b1});

      // Asynchronous reset during HOLD discards the pending shot
      cycle(1'b1, 8'h1C, 1'b0);
      cycle(1'b1, 8'h16, 1'b0);
      cycle(1'b1, 8'h5A, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst", {11'd0, cmd_valid, cmd_player}, {11'd0, 1'b0, 1'b0});
      model_reset();
      reset_n = 1'b1;
      cycle(1'b1, 8'h2B, 1'b0);
      cycle(1'b1, 8'h3E, 1'b0);
      cycle(1'b1, 8'h5A, 1'b0);
      chk("post_rst", {4'd0, cmd_valid, cmd_row, cmd_col}, {4'd0, 1'b1, 4'd5, 4'd7});
      cycle(1'b0, 8'h00, 1'b1);

      // Random traffic, including back-to-back bytes
      for (int i = 0; i < 800; i++) begin
         cycle(($urandom_range(0, 3) != 0),
               rand_pool[$urandom_range(0, 25)],
               1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
